// File: rtl/overflow_exception_unit.sv
// ---------------------------------------------------------------------------
// overflow_exception_unit
//
// CP0-lite trap unit consuming the EX-stage ALU overflow flag. A signed
// overflow on a valid EX instruction records EPC and Cause, sets Status.EXL,
// flushes the front of the pipeline for one cycle and redirects fetch to the
// exception vector. ERET returns fetch to EPC and clears EXL. MFC0/MTC0
// access Status(12), Cause(13), EPC(14) and the saturating OvCount(22).
//
// Ports
//   clock        in   1   rising-edge clock
//   reset_n      in   1   asynchronous active-low reset
//   ex_valid     in   1   EX stage holds a real instruction
//   ex_pc        in   32  PC of the EX instruction
//   ex_overflow  in   1   ALU overflow flag for the EX instruction
//   ex_unsig     in   1   EX instruction is unsigned (never traps)
//   eret         in   1   ERET retiring this cycle
//   mtc0_en      in   1   MTC0 write strobe
//   c0_wreg      in   5   MTC0 target register
//   c0_wdata     in   32  MTC0 write data
//   c0_rreg      in   5   MFC0 source register
//   c0_rdata     out  32  MFC0 read data (combinational)
//   flush        out  1   one-cycle kill of IF/ID/EX
//   redirect     out  1   fetch must load redirect_pc, held until fetch_ack
//   redirect_pc  out  32  redirect target, 0 when redirect is low
//   fetch_ack    in   1   fetch accepted redirect_pc
//   exl          out  1   Status.EXL
// ---------------------------------------------------------------------------
module overflow_exception_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
    parameter int          CNT_W      = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_overflow,
    input  logic        ex_unsig,
    input  logic        eret,
    input  logic        mtc0_en,
    input  logic [4:0]  c0_wreg,
    input  logic [31:0] c0_wdata,
    input  logic [4:0]  c0_rreg,
    output logic [31:0] c0_rdata,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    input  logic        fetch_ack,
    output logic        exl
);

    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_OVCOUNT = 5'd22;
    localparam logic [4:0] EXC_OV      = 5'd12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_VEC     = 3'd2,
        S_HANDLER = 3'd3,
        S_ERET_RD = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      epc_q, epc_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic             exl_q, exl_d;
    logic [CNT_W-1:0] ovcnt_q, ovcnt_d;

    logic trig;
    logic take_trap;
    logic eret_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    assign trig = ex_valid & ex_overflow & ~ex_unsig;

    // A retiring ERET is older than the EX instruction, so it takes priority
    // over a simultaneous overflow; the overflow is only counted.
    assign take_trap = trig && !eret && (state_q == S_IDLE) && !exl_q;
    assign eret_done = (state_q == S_ERET_RD) && fetch_ack;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (eret) begin
                    state_d = S_ERET_RD;
                end else if (take_trap) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH:   state_d = S_VEC;
            S_VEC:     if (fetch_ack) state_d = S_HANDLER;
            S_HANDLER: if (eret) state_d = S_ERET_RD;
            S_ERET_RD: if (fetch_ack) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // CP0 register next-state: hardware updates take priority over MTC0.
    always_comb begin
        epc_d      = epc_q;
        exc_code_d = exc_code_q;
        exl_d      = exl_q;
        ovcnt_d    = ovcnt_q;

        if (take_trap) begin
            epc_d      = ex_pc;
            exc_code_d = EXC_OV;
        end else if (mtc0_en && (c0_wreg == REG_EPC)) begin
            epc_d = c0_wdata;
        end

        if (take_trap) begin
            exl_d = 1'b1;
        end else if (eret_done) begin
            exl_d = 1'b0;
        end else if (mtc0_en && (c0_wreg == REG_STATUS)) begin
            exl_d = c0_wdata[1];
        end

        if (trig) begin
            ovcnt_d = sat_inc(ovcnt_q);
        end else if (mtc0_en && (c0_wreg == REG_OVCOUNT)) begin
            ovcnt_d = c0_wdata[CNT_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            epc_q      <= '0;
            exc_code_q <= '0;
            exl_q      <= 1'b0;
            ovcnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            epc_q      <= epc_d;
            exc_code_q <= exc_code_d;
            exl_q      <= exl_d;
            ovcnt_q    <= ovcnt_d;
        end
    end

    // Outputs decode straight from the state register so an asynchronous
    // reset drops them without waiting for a clock edge.
    always_comb begin
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        unique case (state_q)
            S_FLUSH: flush = 1'b1;
            S_VEC: begin
                redirect    = 1'b1;
                redirect_pc = EXC_VECTOR;
            end
            S_ERET_RD: begin
                redirect    = 1'b1;
                redirect_pc = epc_q;
            end
            default: ;
        endcase
    end

    assign exl = exl_q;

    always_comb begin
        c0_rdata = 32'h0;
        unique case (c0_rreg)
            REG_STATUS:  c0_rdata = {30'b0, exl_q, 1'b0};
            REG_CAUSE:   c0_rdata = {25'b0, exc_code_q, 2'b0};
            REG_EPC:     c0_rdata = epc_q;
            REG_OVCOUNT: c0_rdata = {{(32-CNT_W){1'b0}}, ovcnt_q};
            default:     c0_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_overflow_exception_unit.sv
module tb_overflow_exception_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_overflow, ex_unsig, eret;
    logic [31:0] ex_pc;
    logic        mtc0_en;
    logic [4:0]  c0_wreg, c0_rreg;
    logic [31:0] c0_wdata, c0_rdata;
    logic        flush, redirect, fetch_ack, exl;
    logic [31:0] redirect_pc;

    int n_asrt = 0;
    int n_fail = 0;

    overflow_exception_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_overflow (ex_overflow),
        .ex_unsig    (ex_unsig),
        .eret        (eret),
        .mtc0_en     (mtc0_en),
        .c0_wreg     (c0_wreg),
        .c0_wdata    (c0_wdata),
        .c0_rreg     (c0_rreg),
        .c0_rdata    (c0_rdata),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_ack   (fetch_ack),
        .exl         (exl)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle 1 time unit
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rd(input logic [4:0] r, input string tag, input logic [31:0] exp);
        c0_rreg = r;
        #1;
        check(tag, c0_rdata, exp);
    endtask

    task automatic ctrl(input string tag, input logic f, input logic r,
                        input logic [31:0] pc, input logic x);
        check({tag, ".flush"}, {31'b0, flush}, {31'b0, f});
        check({tag, ".redirect"}, {31'b0, redirect}, {31'b0, r});
        check({tag, ".redirect_pc"}, redirect_pc, pc);
        check({tag, ".exl"}, {31'b0, exl}, {31'b0, x});
    endtask

    task automatic set_ovf(input logic v, input logic o, input logic u, input logic [31:0] pc);
        ex_valid = v; ex_overflow = o; ex_unsig = u; ex_pc = pc;
    endtask

    initial begin
        reset_n = 1'b0;
        set_ovf(0, 0, 0, 32'h0);
        eret = 0; mtc0_en = 0; c0_wreg = 0; c0_wdata = 0; c0_rreg = 0; fetch_ack = 0;
        step(); step();
        ctrl("rst", 0, 0, 32'h0, 0);
        reset_n = 1'b1;
        step();
        rd(5'd12, "rst.status", 32'h0);
        rd(5'd13, "rst.cause", 32'h0);
        rd(5'd14, "rst.epc", 32'h0);
        rd(5'd22, "rst.ovcnt", 32'h0);

        // unsigned overflow: no trap, no count
        set_ovf(1, 1, 1, 32'h0040_0010);
        step();
        set_ovf(0, 0, 0, 32'h0);
        ctrl("unsig.t1", 0, 0, 32'h0, 0);
        step();
        ctrl("unsig.t2", 0, 0, 32'h0, 0);
        rd(5'd22, "unsig.ovcnt", 32'h0);

        // overflow flag on a bubble: ignored
        set_ovf(0, 1, 0, 32'h0040_0010);
        step();
        set_ovf(0, 0, 0, 32'h0);
        ctrl("bubble.t1", 0, 0, 32'h0, 0);
        step();
        ctrl("bubble.t2", 0, 0, 32'h0, 0);
        rd(5'd22, "bubble.ovcnt", 32'h0);

        // signed overflow trap
        set_ovf(1, 1, 0, 32'h0040_0010);
        step();
        set_ovf(0, 0, 0, 32'h0);
        ctrl("trap.flush", 1, 0, 32'h0, 1);
        rd(5'd14, "trap.epc", 32'h0040_0010);
        rd(5'd13, "trap.cause", 32'h0000_0030);
        rd(5'd12, "trap.status", 32'h0000_0002);
        rd(5'd22, "trap.ovcnt", 32'h1);
        step();
        ctrl("trap.vec", 0, 1, 32'h8000_0180, 1);

        // redirect held stable without ack
        for (int i = 0; i < 5; i++) begin
            step();
            ctrl("vec.hold", 0, 1, 32'h8000_0180, 1);
        end
        fetch_ack = 1;
        step();
        fetch_ack = 0;
        ctrl("handler", 0, 0, 32'h0, 1);

        // second overflow inside handler: counted only
        set_ovf(1, 1, 0, 32'h0040_0099);
        step();
        set_ovf(0, 0, 0, 32'h0);
        ctrl("nested", 0, 0, 32'h0, 1);
        rd(5'd22, "nested.ovcnt", 32'h2);
        rd(5'd14, "nested.epc", 32'h0040_0010);
        step();
        ctrl("nested.t2", 0, 0, 32'h0, 1);

        // ERET back to EPC
        eret = 1;
        step();
        eret = 0;
        ctrl("eret.t1", 0, 1, 32'h0040_0010, 1);
        step();
        ctrl("eret.t2", 0, 1, 32'h0040_0010, 1);
        fetch_ack = 1;
        step();
        fetch_ack = 0;
        ctrl("eret.done", 0, 0, 32'h0, 0);

        // overflow traps again
        set_ovf(1, 1, 0, 32'h0040_0020);
        step();
        set_ovf(0, 0, 0, 32'h0);
        ctrl("retrap", 1, 0, 32'h0, 1);
        rd(5'd14, "retrap.epc", 32'h0040_0020);
        rd(5'd22, "retrap.ovcnt", 32'h3);
        step();
        ctrl("retrap.vec", 0, 1, 32'h8000_0180, 1);
        fetch_ack = 1;
        step();
        fetch_ack = 0;

        // MTC0 accesses inside handler
        mtc0_en = 1; c0_wreg = 5'd14; c0_wdata = 32'h1234_5678;
        step();
        c0_wreg = 5'd13; c0_wdata = 32'hFFFF_FFFF;
        step();
        c0_wreg = 5'd22; c0_wdata = 32'h0000_FFFF;
        step();
        mtc0_en = 0;
        rd(5'd14, "mtc0.epc", 32'h1234_5678);
        rd(5'd13, "mtc0.cause", 32'h0000_0030);
        rd(5'd22, "mtc0.ovcnt", 32'h0000_FFFF);
        rd(5'd5, "unknown.reg", 32'h0);
        set_ovf(1, 1, 0, 32'h0040_0030);
        step();
        set_ovf(0, 0, 0, 32'h0);
        rd(5'd22, "sat.ovcnt", 32'h0000_FFFF);
        rd(5'd14, "sat.epc", 32'h1234_5678);
        eret = 1;
        step();
        eret = 0;
        ctrl("eret2", 0, 1, 32'h1234_5678, 1);
        fetch_ack = 1;
        step();
        fetch_ack = 0;
        ctrl("eret2.done", 0, 0, 32'h0, 0);

        // EXL set by software blocks a trap in IDLE
        mtc0_en = 1; c0_wreg = 5'd12; c0_wdata = 32'h0000_0002;
        step();
        mtc0_en = 0;
        rd(5'd12, "mtc0.status", 32'h0000_0002);
        set_ovf(1, 1, 0, 32'h0040_0040);
        step();
        set_ovf(0, 0, 0, 32'h0);
        ctrl("exlblock", 0, 0, 32'h0, 1);
        mtc0_en = 1; c0_wreg = 5'd12; c0_wdata = 32'h0;
        step();
        mtc0_en = 0;
        check("exlclr", {31'b0, exl}, 32'h0);

        // async reset in the middle of VEC
        set_ovf(1, 1, 0, 32'h0040_0050);
        step();
        set_ovf(0, 0, 0, 32'h0);
        step();
        ctrl("prerst.vec", 0, 1, 32'h8000_0180, 1);
        #2;
        reset_n = 1'b0;
        #1;
        ctrl("asyncrst", 0, 0, 32'h0, 0);
        step();
        reset_n = 1'b1;
        step();
        ctrl("postrst", 0, 0, 32'h0, 0);
        rd(5'd12, "postrst.status", 32'h0);
        rd(5'd13, "postrst.cause", 32'h0);
        rd(5'd14, "postrst.epc", 32'h0);
        rd(5'd22, "postrst.ovcnt", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
